// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode classes, run-state encodings and FSM state type for the
// five-stage pipeline controller.
package pipe_ctrl_pkg;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  localparam logic RUN_EXEC = 1'b1;
  localparam logic RUN_IDLE = 1'b0;

  localparam int STALL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_src_decode.sv
// Decodes which register fields of an instruction are read as sources;
// shared by hazard detection and (later) forwarding.
module src_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [15:0] ir,
  output logic        use_r1,
  output logic        use_r2,
  output logic        use_r3
);

  logic [4:0] op;
  assign op = ir[15:11];

  always_comb begin
    use_r1 = 1'b0;
    use_r2 = 1'b0;
    use_r3 = 1'b0;
    case (op)
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC, OP_JMPR,
      OP_ADDI, OP_SUBI, OP_LDIH: use_r1 = 1'b1;
      OP_STORE: begin
        use_r1 = 1'b1;
        use_r2 = 1'b1;
      end
      OP_LOAD, OP_SLL, OP_SRL, OP_SLA, OP_SRA: use_r2 = 1'b1;
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP,
      OP_AND, OP_OR, OP_XOR: begin
        use_r2 = 1'b1;
        use_r3 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Run/stall/flush controller for the five-stage pipeline: start/halt FSM,
// load-use stall insertion, branch squash and saturating debug counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [15:0]      id_ir,
  input  logic [15:0]      ex_ir,
  input  logic [15:0]      mem_ir,
  input  logic             branch_taken,
  output logic             state,
  output logic             halted,
  output logic             stall,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [STALL_W-1:0] STALL_RELOAD = STALL_W'(LOAD_STALL - 1);

  ctrl_state_t cur_state, nxt_state;
  logic [STALL_W-1:0] stall_left, nxt_stall_left;
  logic use_r1, use_r2, use_r3;
  logic hazard, in_exec;

  src_decode u_src_decode (
    .ir     (id_ir),
    .use_r1 (use_r1),
    .use_r2 (use_r2),
    .use_r3 (use_r3)
  );

  assign in_exec = (cur_state == ST_EXEC);
  assign hazard  = (ex_ir[15:11] == OP_LOAD) &&
                   ((use_r1 && (ex_ir[10:8] == id_ir[10:8])) ||
                    (use_r2 && (ex_ir[10:8] == id_ir[6:4]))  ||
                    (use_r3 && (ex_ir[10:8] == id_ir[2:0])));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state  <= ST_IDLE;
      stall_left <= '0;
      cycle_cnt  <= '0;
      stall_cnt  <= '0;
    end else begin
      cur_state  <= nxt_state;
      stall_left <= nxt_stall_left;
      if (in_exec && (cycle_cnt != '1))
        cycle_cnt <= cycle_cnt + 1'b1;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  // A taken branch overrides any pending stall so the PC can move to the
  // target; leaving EXEC also drops whatever stall was in progress.
  always_comb begin
    nxt_state      = cur_state;
    nxt_stall_left = '0;
    stall          = 1'b0;
    bubble_ex      = 1'b0;
    flush_id       = 1'b0;
    case (cur_state)
      ST_IDLE: if (enable && start) nxt_state = ST_EXEC;
      ST_EXEC: begin
        if (!enable)
          nxt_state = ST_IDLE;
        else if (mem_ir[15:11] == OP_HALT)
          nxt_state = ST_HALT;
        if (branch_taken) begin
          flush_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (stall_left != '0) begin
          stall          = 1'b1;
          bubble_ex      = 1'b1;
          nxt_stall_left = stall_left - 1'b1;
        end else if (hazard) begin
          stall          = 1'b1;
          bubble_ex      = 1'b1;
          nxt_stall_left = STALL_RELOAD;
        end
        if (nxt_state != ST_EXEC)
          nxt_stall_left = '0;
      end
      ST_HALT: if (!enable) nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  assign state  = in_exec ? RUN_EXEC : RUN_IDLE;
  assign halted = (cur_state == ST_HALT);

endmodule
